// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-requester SRAM arbiter.
package sram_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/sram_arb_rr.sv
// Two-input round-robin picker: on a tie, grant the requester not granted last.
module sram_arb_rr
  import sram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_c,
  output logic       valid_c
);

  always_comb begin
    valid_c = |req;
    grant_c = REQ0;
    case (req)
      2'b01:   grant_c = REQ0;
      2'b10:   grant_c = REQ1;
      2'b11:   grant_c = ~last_grant;
      default: grant_c = REQ0;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates two requesters onto one SRAM controller port, one access at a time.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_wrEn,
  input  logic              r0_rdEn,
  input  logic [ADDR_W-1:0] r0_address,
  input  logic [DATA_W-1:0] r0_writeData,
  output logic [DATA_W-1:0] r0_readData,
  output logic              r0_ready,
  input  logic              r1_wrEn,
  input  logic              r1_rdEn,
  input  logic [ADDR_W-1:0] r1_address,
  input  logic [DATA_W-1:0] r1_writeData,
  output logic [DATA_W-1:0] r1_readData,
  output logic              r1_ready,
  output logic              mem_wrEn,
  output logic              mem_rdEn,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  input  logic [DATA_W-1:0] mem_readData,
  input  logic              mem_ready
);

  state_t            state_q, state_d;
  logic              take;
  logic              last_grant_q;
  logic              cmd_wr_q, cmd_rd_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_data_q;
  logic              grant_c, valid_c;
  logic              sel_wr, sel_rd;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  sram_arb_rr u_rr (
    .req        ({r1_wrEn | r1_rdEn, r0_wrEn | r0_rdEn}),
    .last_grant (last_grant_q),
    .grant_c    (grant_c),
    .valid_c    (valid_c)
  );

  always_comb begin
    sel_wr   = (grant_c == REQ1) ? r1_wrEn      : r0_wrEn;
    sel_rd   = (grant_c == REQ1) ? r1_rdEn      : r0_rdEn;
    sel_addr = (grant_c == REQ1) ? r1_address   : r0_address;
    sel_data = (grant_c == REQ1) ? r1_writeData : r0_writeData;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // last_grant_q doubles as the index of the in-flight requester while BUSY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= REQ1;
      cmd_wr_q     <= 1'b0;
      cmd_rd_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_data_q   <= '0;
    end else if (take) begin
      last_grant_q <= grant_c;
      cmd_wr_q     <= sel_wr;
      cmd_rd_q     <= sel_rd & ~sel_wr;
      cmd_addr_q   <= sel_addr;
      cmd_data_q   <= sel_data;
    end
  end

  always_comb begin
    state_d       = state_q;
    take          = 1'b0;
    mem_wrEn      = 1'b0;
    mem_rdEn      = 1'b0;
    mem_address   = '0;
    mem_writeData = '0;
    r0_ready      = 1'b0;
    r1_ready      = 1'b0;
    r0_readData   = '0;
    r1_readData   = '0;
    case (state_q)
      IDLE: begin
        if (valid_c) begin
          take    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        mem_wrEn      = cmd_wr_q;
        mem_rdEn      = cmd_rd_q;
        mem_address   = cmd_addr_q;
        mem_writeData = cmd_data_q;
        if (last_grant_q == REQ1) begin
          r1_ready    = mem_ready;
          r1_readData = mem_readData;
        end else begin
          r0_ready    = mem_ready;
          r0_readData = mem_readData;
        end
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed scoreboard bench for sram_arbiter with a scripted SRAM responder.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_wrEn, r0_rdEn, r1_wrEn, r1_rdEn;
  logic [31:0] r0_address, r0_writeData, r0_readData;
  logic [31:0] r1_address, r1_writeData, r1_readData;
  logic        r0_ready, r1_ready;
  logic        mem_wrEn, mem_rdEn, mem_ready;
  logic [31:0] mem_address, mem_writeData, mem_readData;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic        idx;
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .r0_wrEn       (r0_wrEn),
    .r0_rdEn       (r0_rdEn),
    .r0_address    (r0_address),
    .r0_writeData  (r0_writeData),
    .r0_readData   (r0_readData),
    .r0_ready      (r0_ready),
    .r1_wrEn       (r1_wrEn),
    .r1_rdEn       (r1_rdEn),
    .r1_address    (r1_address),
    .r1_writeData  (r1_writeData),
    .r1_readData   (r1_readData),
    .r1_ready      (r1_ready),
    .mem_wrEn      (mem_wrEn),
    .mem_rdEn      (mem_rdEn),
    .mem_address   (mem_address),
    .mem_writeData (mem_writeData),
    .mem_readData  (mem_readData),
    .mem_ready     (mem_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic idx, input logic wr, input logic rd,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (idx) begin
      r1_wrEn = wr; r1_rdEn = rd; r1_address = addr; r1_writeData = wdata;
    end else begin
      r0_wrEn = wr; r0_rdEn = rd; r0_address = addr; r0_writeData = wdata;
    end
  endtask

  // A granted command with both enables set is expected to become write-only.
  task automatic request(input logic idx, input logic wr, input logic rd,
                         input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    drive(idx, wr, rd, addr, wdata);
    e.idx = idx; e.wr = wr; e.rd = rd & ~wr; e.addr = addr; e.wdata = wdata;
    sb.push_back(e);
  endtask

  function automatic logic any_out();
    return |{mem_wrEn, mem_rdEn, mem_address, mem_writeData,
             r0_ready, r1_ready, r0_readData, r1_readData};
  endfunction

  // Waits for the next access, holds it for `busy` cycles, then pulses mem_ready.
  task automatic serve(input int busy, input logic [31:0] rdata,
                       input bit mut, input logic [31:0] mut_addr);
    exp_t e;
    bit   seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk); #1;
      if (mem_wrEn | mem_rdEn) seen = 1;
    end
    chk("grant_wait", 64'(seen), 64'(1));
    if (!seen || sb.size() == 0) return;
    e = sb.pop_front();
    for (int k = 1; k <= busy; k++) begin
      if (k > 1) @(negedge clk);
      if (mut && k == 2) begin
        if (e.idx) r1_address = mut_addr;
        else       r0_address = mut_addr;
      end
      if (k == busy) begin
        mem_readData = rdata;
        mem_ready    = 1'b1;
      end
      #1;
      chk("mem_wrEn",      64'(mem_wrEn),      64'(e.wr));
      chk("mem_rdEn",      64'(mem_rdEn),      64'(e.rd));
      chk("mem_address",   64'(mem_address),   64'(e.addr));
      chk("mem_writeData", 64'(mem_writeData), 64'(e.wdata));
      chk("ready_vec", 64'({r1_ready, r0_ready}),
          64'((k == busy) ? (e.idx ? 2'b10 : 2'b01) : 2'b00));
      if (k == busy) begin
        chk("readData_granted", 64'(e.idx ? r1_readData : r0_readData), 64'(rdata));
        chk("readData_other",   64'(e.idx ? r0_readData : r1_readData), 64'(0));
      end
    end
    @(negedge clk);
    mem_ready    = 1'b0;
    mem_readData = '0;
    drive(e.idx, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("idle_gap", 64'({mem_wrEn, mem_rdEn, r1_ready, r0_ready}), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_outputs", 64'(any_out()), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    mem_ready    = 1'b0;
    mem_readData = '0;

    do_reset();

    // Tie after reset: r0 first, then r1.
    @(negedge clk);
    request(1'b0, 1'b1, 1'b0, 32'h10, 32'h1234);
    request(1'b1, 1'b0, 1'b1, 32'h20, 32'h0);
    serve(3, 32'h0, 0, 32'h0);
    serve(2, 32'hCAFE_0020, 0, 32'h0);

    // Next tie alternates back to r0.
    @(negedge clk);
    request(1'b0, 1'b0, 1'b1, 32'h30, 32'h0);
    request(1'b1, 1'b1, 1'b0, 32'h40, 32'hAAAA_5555);
    serve(2, 32'h1111_2222, 0, 32'h0);
    serve(2, 32'h0, 0, 32'h0);

    // Single read, five BUSY cycles.
    @(negedge clk);
    request(1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'h0);
    serve(5, 32'hDEAD_BEEF, 0, 32'h0);

    // Both enables collapse to write-only.
    @(negedge clk);
    request(1'b1, 1'b1, 1'b1, 32'h8, 32'h0BAD_F00D);
    serve(3, 32'h5A5A_5A5A, 0, 32'h0);

    // Address change mid-access must not reach mem_address.
    @(negedge clk);
    request(1'b0, 1'b0, 1'b1, 32'h100, 32'h0);
    serve(4, 32'h0000_0100, 1, 32'h200);

    // Stray mem_ready in IDLE is ignored.
    @(negedge clk);
    mem_ready = 1'b1;
    mem_readData = 32'hFFFF_FFFF;
    #1;
    chk("stray_ready", 64'({r1_ready, r0_ready}), 64'(0));
    chk("stray_rdata", 64'({r1_readData, r0_readData}), 64'(0));
    @(negedge clk);
    mem_ready = 1'b0;
    mem_readData = '0;
    #1;
    chk("stray_state_idle", 64'({mem_wrEn, mem_rdEn}), 64'(0));
    request(1'b1, 1'b0, 1'b1, 32'h50, 32'h0);
    serve(2, 32'h7777_0050, 0, 32'h0);

    // Reset on the second BUSY cycle abandons the access.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h60, 32'h0);
    @(negedge clk); #1;
    chk("pre_reset_busy", 64'(mem_address), 64'(32'h60));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midbusy_reset_outputs", 64'(any_out()), 64'(0));
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk); #1;
    chk("reset_no_ready", 64'({r1_ready, r0_ready}), 64'(0));
    rst = 1'b1;

    // First tie after reset release goes to r0 again.
    @(negedge clk);
    request(1'b0, 1'b1, 1'b0, 32'h70, 32'h0000_7070);
    request(1'b1, 1'b0, 1'b1, 32'h80, 32'h0);
    serve(2, 32'h0, 0, 32'h0);
    serve(2, 32'h8080_8080, 0, 32'h0);

    chk("scoreboard_empty", 64'(sb.size()), 64'(0));

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, requester/memory address width.
REQ-002 Parameter DATA_W, default 32, requester/memory data width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 r0_wrEn, r0_rdEn  input  1 each  requester 0 (data/MEM-stage) write/read request.
REQ-007 r0_address  input  ADDR_W; r0_writeData  input  DATA_W  requester 0 command fields.
REQ-008 r0_readData  output  DATA_W; r0_ready  output  1  requester 0 response and completion.
REQ-009 r1_wrEn, r1_rdEn, r1_address, r1_writeData, r1_readData, r1_ready  same widths and directions as r0_*, for requester 1.
REQ-010 mem_wrEn, mem_rdEn  output  1 each; mem_address  output  ADDR_W; mem_writeData  output  DATA_W  command to the SRAM controller.
REQ-011 mem_readData  input  DATA_W; mem_ready  input  1  SRAM controller response; mem_ready is a 1-cycle completion pulse.

Function
REQ-012 Requester protocol SHALL be: hold wrEn/rdEn with stable fields until rX_ready=1 for one cycle; any enable seen after that cycle is a new request.
REQ-013 FSM states: IDLE, BUSY.
REQ-014 In IDLE, if any requester has wrEn|rdEn=1, the arbiter SHALL grant one, latch its wrEn, rdEn, address and writeData, and enter BUSY at the next edge.
REQ-015 Arbitration SHALL be round-robin: if both request, grant the one not recorded in last_grant; if one requests, grant it; last_grant updates on each grant.
REQ-016 If a granted request has wrEn=1 and rdEn=1, the latched command SHALL be write-only (rdEn cleared).
REQ-017 In BUSY, mem_* SHALL be driven solely from the latched command; in IDLE, mem_wrEn=mem_rdEn=0 and mem_address=mem_writeData=0.
REQ-018 In BUSY, when mem_ready=1, the granted rX_ready SHALL be 1 in the same cycle (combinational), and the FSM returns to IDLE at that edge.
REQ-019 rX_readData SHALL equal mem_readData for the granted requester while in BUSY, and 0 otherwise.
REQ-020 The non-granted requester's ready SHALL be 0 at all times; mem_ready while in IDLE SHALL be ignored.
REQ-021 Changes to requester inputs during BUSY SHALL not alter the in-flight command; a requester dropping its enable mid-access still has its access completed.
REQ-022 Minimum spacing: one IDLE cycle between consecutive accesses; a waiting requester SHALL be granted no later than the second IDLE following its request assertion.
REQ-023 No combinational path from rX_* inputs to mem_* outputs.

Reset
REQ-024 On rst=0, asynchronously: state=IDLE; latched command cleared; last_grant=1 (requester 0 wins the first tie); all outputs 0.
REQ-025 Reset during BUSY SHALL abandon the access with no rX_ready pulse; the SRAM controller shares rst.

Structure
REQ-026 Shared package holds the state enum (IDLE, BUSY) and requester index constants REQ0=0, REQ1=1.
REQ-027 One sub-module: sram_arb_rr, a 2-input round-robin picker (inputs req[1:0], last_grant; output grant index, valid).

Verification
REQ-028 Single read: r0_rdEn=1, addr 0x0000_0400; mem_ready after 5 BUSY cycles, mem_readData=0xDEAD_BEEF -> mem_rdEn=1 with addr 0x400 for 5 cycles; r0_ready=1, r0_readData=0xDEADBEEF in the same cycle; r1_ready=0.
REQ-029 Simultaneous requests after reset: r0 write 0x10/0x1234, r1 read 0x20 -> r0 served first, then r1; next tie goes to r0 (alternation).
REQ-030 Both enables: r1_wrEn=r1_rdEn=1, addr 0x8 -> mem_wrEn=1, mem_rdEn=0 for the entire access.
REQ-031 Input change mid-access: r0 read 0x100 granted, then r0_address changes to 0x200 during BUSY -> mem_address stays 0x100 until mem_ready.
REQ-032 Reset mid-BUSY: assert rst=0 on the 2nd BUSY cycle -> all outputs 0 immediately, no ready pulse; after release the first tie grants r0.
REQ-033 Stray mem_ready=1 in IDLE -> both rX_ready remain 0 and the state stays IDLE.
